// File: rtl/alarm_ring_controller_pkg.sv
// Shared types and widths for the alarm ring controller and its helpers.
package alarm_ring_controller_pkg;

  localparam int SNOOZE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RING    = 2'd1,
    ST_SNOOZE  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

endpackage

// File: rtl/alarm_ring_controller_second_counter.sv
// Counts 1 Hz ticks while not cleared; done pulses on the tick that completes TERMINAL seconds.
module alarm_ring_controller_second_counter #(
  parameter int TERMINAL = 60
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick_1hz,
  output logic done
);

  localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holds at the last value instead of wrapping; the owner clears it on state exit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick_1hz && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = tick_1hz & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/alarm_ring_controller.sv
// Ring/snooze/stop state machine fed by the alarm-match OR line; drives buzzer and status LEDs.
module alarm_ring_controller
  import alarm_ring_controller_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick_1hz,
  input  logic                    trigger,
  input  logic                    enable,
  input  logic                    snooze_btn,
  input  logic                    stop_btn,
  output logic                    buzzer,
  output logic                    ringing,
  output logic                    snoozing,
  output logic [SNOOZE_CNT_W-1:0] snooze_count
);

  localparam logic [SNOOZE_CNT_W-1:0] MAX_CNT = SNOOZE_CNT_W'(MAX_SNOOZES);

  state_e                  state_q, state_d;
  logic                    trigger_q, trigger_d;
  logic                    beep_phase_q, beep_phase_d;
  logic [SNOOZE_CNT_W-1:0] snooze_count_q, snooze_count_d;
  logic                    buzzer_q, buzzer_d;
  logic                    ringing_q, ringing_d;
  logic                    snoozing_q, snoozing_d;
  logic                    rise;
  logic                    ring_clear, snooze_clear;
  logic                    ring_done, snooze_done;

  assign trigger_d    = trigger;
  assign rise         = trigger & ~trigger_q;
  assign ring_clear   = (state_q != ST_RING);
  assign snooze_clear = (state_q != ST_SNOOZE);

  alarm_ring_controller_second_counter #(.TERMINAL(RING_TIMEOUT_S)) u_ring_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (ring_clear),
    .tick_1hz (tick_1hz),
    .done     (ring_done)
  );

  alarm_ring_controller_second_counter #(.TERMINAL(SNOOZE_S)) u_snooze_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (snooze_clear),
    .tick_1hz (tick_1hz),
    .done     (snooze_done)
  );

  always_comb begin
    state_d        = state_q;
    snooze_count_d = snooze_count_q;
    beep_phase_d   = beep_phase_q;
    if (!enable) begin
      state_d        = ST_IDLE;
      snooze_count_d = '0;
      beep_phase_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d        = ST_RING;
            snooze_count_d = '0;
            beep_phase_d   = 1'b0;
          end
        end
        ST_RING: begin
          if (tick_1hz) begin
            beep_phase_d = ~beep_phase_q;
          end
          if (stop_btn) begin
            state_d = ST_LOCKOUT;
          end else if (snooze_btn && (snooze_count_q < MAX_CNT)) begin
            state_d        = ST_SNOOZE;
            snooze_count_d = snooze_count_q + 1'b1;
          end else if (ring_done) begin
            state_d = ST_LOCKOUT;
          end
        end
        ST_SNOOZE: begin
          if (stop_btn) begin
            state_d = ST_LOCKOUT;
          end else if (snooze_done) begin
            state_d      = ST_RING;
            beep_phase_d = 1'b0;
          end
        end
        ST_LOCKOUT: begin
          // Hold off until the matching minute ends so the same match cannot re-ring.
          if (!trigger) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ringing_d  = (state_d == ST_RING);
    snoozing_d = (state_d == ST_SNOOZE);
    buzzer_d   = (state_d == ST_RING) & beep_phase_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      trigger_q      <= 1'b1;
      beep_phase_q   <= 1'b0;
      snooze_count_q <= '0;
      buzzer_q       <= 1'b0;
      ringing_q      <= 1'b0;
      snoozing_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      trigger_q      <= trigger_d;
      beep_phase_q   <= beep_phase_d;
      snooze_count_q <= snooze_count_d;
      buzzer_q       <= buzzer_d;
      ringing_q      <= ringing_d;
      snoozing_q     <= snoozing_d;
    end
  end

  assign buzzer       = buzzer_q;
  assign ringing      = ringing_q;
  assign snoozing     = snoozing_q;
  assign snooze_count = snooze_count_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Scenario bench for alarm_ring_controller: expected outputs are queued as stimulus is driven
// and compared against the outputs captured right after the corresponding clock edge.
module tb_alarm_ring_controller;

  logic       clock;
  logic       reset;
  logic       tick_1hz;
  logic       trigger;
  logic       enable;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [3:0] snooze_count;

  typedef struct packed {
    logic       ring;
    logic       snz;
    logic       buz;
    logic [3:0] cnt;
  } outs_t;

  outs_t exp_q[$];
  outs_t obs_q[$];
  string name_q[$];

  int total  = 0;
  int passed = 0;

  alarm_ring_controller #(
    .RING_TIMEOUT_S (5),
    .SNOOZE_S       (3),
    .MAX_SNOOZES    (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .trigger      (trigger),
    .enable       (enable),
    .snooze_btn   (snooze_btn),
    .stop_btn     (stop_btn),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_count (snooze_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sets levels, runs `pre` quiet cycles, then one cycle with the given pulses.
  // The expected result is queued with the stimulus; the post-edge outputs are captured.
  task automatic stim(input int pre, input logic trig, input logic en, input logic tk,
                      input logic snz, input logic stp, input logic rst,
                      input logic e_ring, input logic e_snz, input logic e_buz,
                      input logic [3:0] e_cnt, input string name);
    outs_t e;
    outs_t o;
    trigger = trig;
    enable  = en;
    repeat (pre) begin
      @(posedge clock);
      #1;
    end
    tick_1hz   = tk;
    snooze_btn = snz;
    stop_btn   = stp;
    reset      = rst;
    e.ring = e_ring;
    e.snz  = e_snz;
    e.buz  = e_buz;
    e.cnt  = e_cnt;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clock);
    #1;
    o.ring = ringing;
    o.snz  = snoozing;
    o.buz  = buzzer;
    o.cnt  = snooze_count;
    obs_q.push_back(o);
    tick_1hz   = 1'b0;
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic test_reset();
    outs_t e;
    outs_t o;
    string n;
    stim(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "reset_outputs");
    stim(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "reset_held");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "no_ring_trigger_high_from_reset");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "still_idle_second_tick");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (o !== e)
        $display("[TB] FAIL %s: got ring=%b snz=%b buz=%b cnt=%0d, want ring=%b snz=%b buz=%b cnt=%0d",
                 n, o.ring, o.snz, o.buz, o.cnt, e.ring, e.snz, e.buz, e.cnt);
      else
        passed++;
    end
  endtask

  task automatic test_ring_timeout();
    outs_t e;
    outs_t o;
    string n;
    stim(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "trigger_low");
    stim(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "ring_start");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, "beep_tick1");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, "beep_tick2");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, "beep_tick3");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, "beep_tick4");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "ring_timeout");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "lockout_hold");
    stim(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, "buttons_in_lockout");
    stim(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "lockout_exit");
    stim(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "ring_after_lockout");
    stim(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, "stop_btn");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (o !== e)
        $display("[TB] FAIL %s: got ring=%b snz=%b buz=%b cnt=%0d, want ring=%b snz=%b buz=%b cnt=%0d",
                 n, o.ring, o.snz, o.buz, o.cnt, e.ring, e.snz, e.buz, e.cnt);
      else
        passed++;
    end
  endtask

  task automatic test_snooze();
    outs_t e;
    outs_t o;
    string n;
    stim(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "snz_prep_low");
    stim(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "snz_prep_ring");
    stim(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, "snooze1");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, "snooze1_tick1");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, "snooze1_tick2");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, "resume1");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 1, 1, "resume1_beep");
    stim(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 2, "snooze2");
    stim(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 2, "snooze_btn_in_snooze");
    stim(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2, "trigger_low_in_snooze");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 1, 0, 2, "snooze2_tick1");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 1, 0, 2, "snooze2_tick2");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 0, 2, "resume2");
    stim(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 2, "snooze3_ignored");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 1, 2, "max_tick1");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 0, 2, "max_tick2");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 1, 2, "max_tick3");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 0, 2, "max_tick4");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2, "timeout_after_max");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (o !== e)
        $display("[TB] FAIL %s: got ring=%b snz=%b buz=%b cnt=%0d, want ring=%b snz=%b buz=%b cnt=%0d",
                 n, o.ring, o.snz, o.buz, o.cnt, e.ring, e.snz, e.buz, e.cnt);
      else
        passed++;
    end
  endtask

  task automatic test_stop_and_snooze();
    outs_t e;
    outs_t o;
    string n;
    stim(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, "lockout_to_idle_keeps_count");
    stim(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "ring_clears_count");
    stim(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, "snooze_once");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, "snz_tick1");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, "snz_tick2");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, "snz_resume");
    stim(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, "stop_beats_snooze");
    stim(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "glitch_low");
    stim(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "glitch_rering");
    stim(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, "snooze_then_stop_prep");
    stim(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, "stop_in_snooze");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (o !== e)
        $display("[TB] FAIL %s: got ring=%b snz=%b buz=%b cnt=%0d, want ring=%b snz=%b buz=%b cnt=%0d",
                 n, o.ring, o.snz, o.buz, o.cnt, e.ring, e.snz, e.buz, e.cnt);
      else
        passed++;
    end
  endtask

  task automatic test_enable_drop();
    outs_t e;
    outs_t o;
    string n;
    stim(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "en_prep_low");
    stim(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "en_prep_ring");
    stim(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, "en_snooze");
    stim(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "enable_drop");
    stim(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "reenable_trigger_high");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reenable_still_idle");
    stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "disabled_low");
    stim(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "disabled_rise_ignored");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (o !== e)
        $display("[TB] FAIL %s: got ring=%b snz=%b buz=%b cnt=%0d, want ring=%b snz=%b buz=%b cnt=%0d",
                 n, o.ring, o.snz, o.buz, o.cnt, e.ring, e.snz, e.buz, e.cnt);
      else
        passed++;
    end
  endtask

  task automatic test_reset_mid();
    outs_t e;
    outs_t o;
    string n;
    stim(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "rm_prep_low");
    stim(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "rm_ring");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, "rm_beep");
    stim(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "reset_mid_count");
    stim(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "no_ring_after_reset");
    stim(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "rm_trigger_low");
    stim(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "fresh_rise_rings");
    stim(3, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, "fresh_ring_beep");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (o !== e)
        $display("[TB] FAIL %s: got ring=%b snz=%b buz=%b cnt=%0d, want ring=%b snz=%b buz=%b cnt=%0d",
                 n, o.ring, o.snz, o.buz, o.cnt, e.ring, e.snz, e.buz, e.cnt);
      else
        passed++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    tick_1hz   = 1'b0;
    trigger    = 1'b1;
    enable     = 1'b1;
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_stop_and_snooze();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
